gppcu_issue_ctrl: RTL and testbench
===================================

# gppcu_issue_ctrl

Parametrised in-order issue controller for the GPPCU SIMD core. It buffers incoming instruction words in a small FIFO and resolves register hazards with a NUMREG-entry scoreboard. It sequences a four-stage Q/D/E/W valid pipeline whose stage instruction words feed every lane. New relative to the previous generation:
- instruction buffering with a ready/valid input;
- REQ/ACK global-memory fetch with wait states, replacing the gated-clock read;
- queue flush;
- optional performance counters.

## Interface
Parameters:
- DBW, 32: instruction/data width.
- NUMREG, 32: scoreboard entries. Power of 2, at most 32.
- FIFO_DEPTH, 4: instruction queue depth. Power of 2, at least 2.
- GBW, 17: global memory address width.

Ports:
- iACLK  in  1  clock; everything is on the rising edge.
- inRST  in  1  reset, synchronous, active-low.
- iINSTR  in  DBW  instruction word.
- iINSTR_VALID  in  1  push request.
- oINSTR_READY  out  1  queue can accept a word.
- oHEAD_INSTR  out  DBW  queue head word, routed to the external decoder.
- iHEAD_REGWR / iHEAD_USEA / iHEAD_USEB / iHEAD_GMEMRD  in  1 each  decoder response for the head word, combinational.
- iBUSY  in  1  lane-0 multi-cycle unit busy.
- oGMEM_REQ  out  1  global read request.
- oGMEM_ADDR  out  GBW  global read address.
- iGMEM_ACK  in  1  read done; data valid this cycle.
- iGMEM_RDATA  in  DBW  read data.
- oGMEM_DATA  out  DBW  captured read data, aligned with the D stage.
- iFLUSH  in  1  discard queue contents.
- oVALID_DEC / oVALID_EXEC / oVALID_WB  out  1 each  stage valid flags.
- oINSTR_DEC / oINSTR_EXEC / oINSTR_WB  out  DBW each  stage instruction words.
- oSTALL  out  1  the head is valid but not issuing this cycle.

## Operation
- **Word layout:**
  - opcode [31:27], regD [26:22], regA [21:17], regB [16:12], imm [GBW-1:0].
  - Register indices are truncated to log2(NUMREG) bits.
- **Queue:**
  - A push occurs when iINSTR_VALID & oINSTR_READY.
  - oINSTR_READY = ~full & ~iFLUSH.
  - Simultaneous push and pop leave the count unchanged.
- **Hazard:** asserted when the head is valid and any of the following holds:
  - iHEAD_USEA and pending[regA];
  - iHEAD_USEB and pending[regB];
  - iHEAD_REGWR and pending[regD] (WAW).
- **GMEM handshake:**
  - oGMEM_REQ = head valid & iHEAD_GMEMRD & ~hazard & ~iBUSY.
  - oGMEM_ADDR = head imm.
  - The head is held, with REQ and ADDR stable, until iGMEM_ACK.
  - ACK while REQ is low is ignored.
- **Issue:**
  - issue = head valid & ~hazard & ~iBUSY & (~iHEAD_GMEMRD | iGMEM_ACK).
  - On issue: pop the queue; D <= head with valid 1; if GMEMRD, oGMEM_DATA <= iGMEM_RDATA.
  - On no issue while ~iBUSY: D <= bubble.
- **Advance:**
  - If ~iBUSY: E <= D.
  - If iBUSY: D and the head are held and E <= bubble.
  - W <= E unconditionally.
- **Scoreboard:**
  - Set pending[regD] on issue with iHEAD_REGWR.
  - Clear pending[regD of W] at the end of a W cycle with a valid REGWR.
  - If set and clear hit the same register in the same cycle, set wins.
  - No bypass: a clear is visible the following cycle.
- **Flush:**
  - iFLUSH empties the queue at the edge and drops any outstanding REQ; ACK in that cycle is ignored.
  - A push in the flush cycle is discarded.
  - D/E/W and the scoreboard drain normally.
- **Reset (inRST = 0):**
  - All valids 0, stage words 0, pending 0, queue empty.
  - oGMEM_REQ 0, oGMEM_DATA 0, oINSTR_READY 0, oSTALL 0.

## Timing
- A word pushed in cycle N is at the head in N+1.
- Earliest issue is at the end of N+1, giving D in N+2, E in N+3, W in N+4.
- Back-to-back independent words issue every cycle.
- RAW distance: producer issues at the end of cycle c, so it occupies D c+1, E c+2, W c+3.
  - Pending clears at the end of c+3.
  - The consumer issues at the end of c+4, so it reaches D in c+5.
  - The result is 3 bubbles in D.
- A GMEM word issues in the ACK cycle; its data is on oGMEM_DATA during its D cycle.
- Zero wait states give REQ and ACK in the same cycle, at full rate.

## Configuration
- GPPCU_ISSUE_PERF_EN defined:
  - Adds 32-bit output oISSUE_CNT, incremented per issue.
  - Adds 32-bit output oSTALL_CNT, incremented per cycle with oSTALL.
  - Both counters wrap, and reset to 0.
- Undefined: neither port nor counter logic exists.

## Structure
- Package gppcu_pkg holds:
  - word-field position constants (INSTR_OPR_5, INSTR_REGD_5, INSTR_REGA_5, INSTR_REGB_5, INSTR_IMM2_17);
  - CW bit indices.
- One sub-module, gppcu_scoreboard, parametrised by NUMREG:
  - inputs: set index/enable and clear index/enable;
  - outputs: three lookup results.

## Test plan
- **Throughput:** push 8 independent words (regD 1..8, no reads). Required: oVALID_DEC high 8 consecutive cycles starting 2 cycles after the first push; oSTALL never high.
- **RAW:** push "write r3" then "read r3 as A". Required: exactly 3 bubble cycles in D between them; oSTALL high for 3 cycles.
- **GMEM wait:** a GMEMRD word with imm 0x1ABCD, ACK after 4 cycles with RDATA 0xDEADBEEF. Required: REQ high 4 cycles with ADDR 0x1ABCD; oGMEM_DATA = 0xDEADBEEF during that word's D cycle.
- **Full queue with iBUSY:** with FIFO_DEPTH 4 and iBUSY held high, push 6 words. Required: oINSTR_READY low after 4 accepted; E shows bubbles; release iBUSY and all 4 issue in order.
- **Flush:** flush while 3 queued and one GMEM REQ pending. Required: REQ drops next cycle; queue empty; D/E/W drain; the scoreboard clears the drained writes.
- **Reset mid-operation:** assert inRST with pending r5 and E valid. Required: all valids and REQ are 0 next cycle, and a later read of r5 issues with no stall.

Source files
------------

// File: rtl/gppcu_pkg.sv
// Shared constants for the GPPCU issue controller: instruction word field
// positions and control-word bit indices for the decoder response.
package gppcu_pkg;

  localparam int INSTR_OPR_5   = 27;
  localparam int INSTR_REGD_5  = 22;
  localparam int INSTR_REGA_5  = 17;
  localparam int INSTR_REGB_5  = 12;
  localparam int INSTR_IMM2_17 = 0;

  localparam int CW_REGWR  = 0;
  localparam int CW_USEA   = 1;
  localparam int CW_USEB   = 2;
  localparam int CW_GMEMRD = 3;
  localparam int CW_W      = 4;

  typedef logic [CW_W-1:0] cw_t;

endpackage

// File: rtl/gppcu_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue
// of a writer and cleared when that writer leaves the W stage.
module gppcu_scoreboard #(
  parameter int NUMREG = 32,
  parameter int RW     = $clog2(NUMREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [RW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [RW-1:0] clr_idx,
  input  logic [RW-1:0] look_a_idx,
  input  logic [RW-1:0] look_b_idx,
  input  logic [RW-1:0] look_d_idx,
  output logic          pend_a,
  output logic          pend_b,
  output logic          pend_d
);

  logic [NUMREG-1:0] pending_q, pending_d;
  logic [NUMREG-1:0] set_hit, clr_hit;

  for (genvar gi = 0; gi < NUMREG; gi++) begin : g_entry
    localparam logic [RW-1:0] IDX = RW'(gi);
    assign set_hit[gi] = set_en & (set_idx == IDX);
    assign clr_hit[gi] = clr_en & (clr_idx == IDX);
  end

  // A set and a clear on the same register in one cycle leaves it pending.
  always_comb begin
    pending_d = (pending_q & ~clr_hit) | set_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pend_a = pending_q[look_a_idx];
  assign pend_b = pending_q[look_b_idx];
  assign pend_d = pending_q[look_d_idx];

endmodule

// File: rtl/gppcu_issue_ctrl.sv
// In-order issue controller: instruction queue, scoreboard hazard check,
// REQ/ACK global read and Q/D/E/W valid pipeline. GPPCU_ISSUE_PERF_EN adds counters.
module gppcu_issue_ctrl
  import gppcu_pkg::*;
#(
  parameter int DBW        = 32,
  parameter int NUMREG     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int GBW        = 17
) (
  input  logic           iACLK,
  input  logic           inRST,
  input  logic [DBW-1:0] iINSTR,
  input  logic           iINSTR_VALID,
  output logic           oINSTR_READY,
  output logic [DBW-1:0] oHEAD_INSTR,
  input  logic           iHEAD_REGWR,
  input  logic           iHEAD_USEA,
  input  logic           iHEAD_USEB,
  input  logic           iHEAD_GMEMRD,
  input  logic           iBUSY,
  output logic           oGMEM_REQ,
  output logic [GBW-1:0] oGMEM_ADDR,
  input  logic           iGMEM_ACK,
  input  logic [DBW-1:0] iGMEM_RDATA,
  output logic [DBW-1:0] oGMEM_DATA,
  input  logic           iFLUSH,
  output logic           oVALID_DEC,
  output logic           oVALID_EXEC,
  output logic           oVALID_WB,
  output logic [DBW-1:0] oINSTR_DEC,
  output logic [DBW-1:0] oINSTR_EXEC,
  output logic [DBW-1:0] oINSTR_WB,
  output logic           oSTALL
`ifdef GPPCU_ISSUE_PERF_EN
  ,
  output logic [31:0]    oISSUE_CNT,
  output logic [31:0]    oSTALL_CNT
`endif
);

  localparam int RW = $clog2(NUMREG);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  logic [DBW-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]    count_q, count_d;
  logic           head_valid, full, push, issue, hazard;
  logic           pend_a, pend_b, pend_d;
  cw_t            head_cw;

  logic           dec_valid_q, dec_valid_d, exec_valid_q, exec_valid_d, wb_valid_q, wb_valid_d;
  logic           dec_regwr_q, dec_regwr_d, exec_regwr_q, exec_regwr_d, wb_regwr_q, wb_regwr_d;
  logic [DBW-1:0] dec_instr_q, dec_instr_d, exec_instr_q, exec_instr_d, wb_instr_q, wb_instr_d;
  logic [DBW-1:0] gmem_data_q, gmem_data_d;

  assign head_valid   = (count_q != '0);
  assign full         = (count_q == FULL_CNT);
  assign oINSTR_READY = inRST & ~full & ~iFLUSH;
  assign push         = iINSTR_VALID & oINSTR_READY;
  assign oHEAD_INSTR  = head_valid ? fifo_mem_q[rd_ptr_q] : '0;
  assign head_cw      = {iHEAD_GMEMRD, iHEAD_USEB, iHEAD_USEA, iHEAD_REGWR};

  gppcu_scoreboard #(.NUMREG(NUMREG)) u_scoreboard (
    .clk        (iACLK),
    .rst_n      (inRST),
    .set_en     (issue & head_cw[CW_REGWR]),
    .set_idx    (oHEAD_INSTR[INSTR_REGD_5 +: RW]),
    .clr_en     (wb_valid_q & wb_regwr_q),
    .clr_idx    (wb_instr_q[INSTR_REGD_5 +: RW]),
    .look_a_idx (oHEAD_INSTR[INSTR_REGA_5 +: RW]),
    .look_b_idx (oHEAD_INSTR[INSTR_REGB_5 +: RW]),
    .look_d_idx (oHEAD_INSTR[INSTR_REGD_5 +: RW]),
    .pend_a     (pend_a),
    .pend_b     (pend_b),
    .pend_d     (pend_d)
  );

  // A flush cycle never issues, so an ACK arriving with it is dropped.
  always_comb begin
    hazard = head_valid & ((head_cw[CW_USEA] & pend_a) |
                           (head_cw[CW_USEB] & pend_b) |
                           (head_cw[CW_REGWR] & pend_d));
    oGMEM_REQ = inRST & head_valid & head_cw[CW_GMEMRD] & ~hazard & ~iBUSY;
    issue = inRST & head_valid & ~hazard & ~iBUSY & ~iFLUSH &
            (~head_cw[CW_GMEMRD] | iGMEM_ACK);
    oSTALL = inRST & head_valid & ~issue;
  end

  assign oGMEM_ADDR = oHEAD_INSTR[INSTR_IMM2_17 +: GBW];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (iFLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !issue)      count_d = count_q + 1'b1;
      else if (!push && issue) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge iACLK) begin
    if (push) fifo_mem_q[wr_ptr_q] <= iINSTR;
  end

  // A busy lane 0 freezes D (and the head) while E receives bubbles; W always follows E.
  always_comb begin
    dec_valid_d  = dec_valid_q;
    dec_regwr_d  = dec_regwr_q;
    dec_instr_d  = dec_instr_q;
    exec_valid_d = 1'b0;
    exec_regwr_d = 1'b0;
    exec_instr_d = '0;
    wb_valid_d   = exec_valid_q;
    wb_regwr_d   = exec_regwr_q;
    wb_instr_d   = exec_instr_q;
    gmem_data_d  = gmem_data_q;
    if (!iBUSY) begin
      dec_valid_d  = issue;
      dec_regwr_d  = issue & head_cw[CW_REGWR];
      dec_instr_d  = issue ? oHEAD_INSTR : '0;
      exec_valid_d = dec_valid_q;
      exec_regwr_d = dec_regwr_q;
      exec_instr_d = dec_instr_q;
    end
    if (issue && head_cw[CW_GMEMRD]) gmem_data_d = iGMEM_RDATA;
  end

  always_ff @(posedge iACLK) begin
    if (!inRST) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dec_valid_q  <= 1'b0;
      dec_regwr_q  <= 1'b0;
      dec_instr_q  <= '0;
      exec_valid_q <= 1'b0;
      exec_regwr_q <= 1'b0;
      exec_instr_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_regwr_q   <= 1'b0;
      wb_instr_q   <= '0;
      gmem_data_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dec_valid_q  <= dec_valid_d;
      dec_regwr_q  <= dec_regwr_d;
      dec_instr_q  <= dec_instr_d;
      exec_valid_q <= exec_valid_d;
      exec_regwr_q <= exec_regwr_d;
      exec_instr_q <= exec_instr_d;
      wb_valid_q   <= wb_valid_d;
      wb_regwr_q   <= wb_regwr_d;
      wb_instr_q   <= wb_instr_d;
      gmem_data_q  <= gmem_data_d;
    end
  end

  assign oVALID_DEC  = dec_valid_q;
  assign oVALID_EXEC = exec_valid_q;
  assign oVALID_WB   = wb_valid_q;
  assign oINSTR_DEC  = dec_instr_q;
  assign oINSTR_EXEC = exec_instr_q;
  assign oINSTR_WB   = wb_instr_q;
  assign oGMEM_DATA  = gmem_data_q;

`ifdef GPPCU_ISSUE_PERF_EN
  logic [31:0] issue_cnt_q, issue_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q + 32'(issue);
    stall_cnt_d = stall_cnt_q + 32'(oSTALL);
  end

  always_ff @(posedge iACLK) begin
    if (!inRST) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign oISSUE_CNT = issue_cnt_q;
  assign oSTALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_gppcu_issue_ctrl.sv
// Directed testbench for gppcu_issue_ctrl: throughput, RAW, GMEM wait states,
// full queue under busy, flush and mid-operation reset.
`timescale 1ns/1ps
module tb_gppcu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid, instr_ready;
  logic [31:0] head_instr;
  logic        head_regwr, head_usea, head_useb, head_gmemrd;
  logic        busy;
  logic        gmem_req, gmem_ack;
  logic [16:0] gmem_addr;
  logic [31:0] gmem_rdata, gmem_data;
  logic        flush;
  logic        dv, ev, wv;
  logic [31:0] dec_instr, exec_instr, wb_instr;
  logic        stall;
`ifdef GPPCU_ISSUE_PERF_EN
  logic [31:0] issue_cnt, stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Bench-side decoder: opcode bit 0 = REGWR, 1 = USEA, 2 = USEB, 3 = GMEMRD.
  assign head_regwr  = head_instr[27];
  assign head_usea   = head_instr[28];
  assign head_useb   = head_instr[29];
  assign head_gmemrd = head_instr[30];

  gppcu_issue_ctrl dut (
    .iACLK        (clk),
    .inRST        (rst_n),
    .iINSTR       (instr),
    .iINSTR_VALID (instr_valid),
    .oINSTR_READY (instr_ready),
    .oHEAD_INSTR  (head_instr),
    .iHEAD_REGWR  (head_regwr),
    .iHEAD_USEA   (head_usea),
    .iHEAD_USEB   (head_useb),
    .iHEAD_GMEMRD (head_gmemrd),
    .iBUSY        (busy),
    .oGMEM_REQ    (gmem_req),
    .oGMEM_ADDR   (gmem_addr),
    .iGMEM_ACK    (gmem_ack),
    .iGMEM_RDATA  (gmem_rdata),
    .oGMEM_DATA   (gmem_data),
    .iFLUSH       (flush),
    .oVALID_DEC   (dv),
    .oVALID_EXEC  (ev),
    .oVALID_WB    (wv),
    .oINSTR_DEC   (dec_instr),
    .oINSTR_EXEC  (exec_instr),
    .oINSTR_WB    (wb_instr),
    .oSTALL       (stall)
`ifdef GPPCU_ISSUE_PERF_EN
    ,
    .oISSUE_CNT   (issue_cnt),
    .oSTALL_CNT   (stall_cnt)
`endif
  );

  function automatic logic [31:0] mk(input logic wr, input logic ua, input logic ub,
                                     input logic gm, input logic [4:0] rd,
                                     input logic [4:0] ra, input logic [16:0] imm);
    mk = {1'b0, gm, ub, ua, wr, rd, ra, imm};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    gmem_ack    = 1'b0;
    flush       = 1'b0;
    busy        = 1'b0;
    repeat (n) cyc();
  endtask

  logic [31:0] thr_w [8];
  logic [31:0] bw    [6];
  logic [31:0] w_p, w_c, w_g, w_x, w_g2, w_y, w_z, w_q, w_r;
  logic [15:0] exp_bits;

  initial begin
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; busy = 1'b0;
    gmem_ack = 1'b0; gmem_rdata = '0; flush = 1'b0;

    // ---------------- reset state
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_dv", dv, 1'b0);
    chk1("rst_ev", ev, 1'b0);
    chk1("rst_wv", wv, 1'b0);
    chk1("rst_req", gmem_req, 1'b0);
    chk1("rst_ready", instr_ready, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk32("rst_gdata", gmem_data, 32'h0);
    chk32("rst_dec_instr", dec_instr, 32'h0);
    chk32("rst_wb_instr", wb_instr, 32'h0);
    rst_n = 1'b1;
    #1;
    chk1("rst_ready_release", instr_ready, 1'b1);

    // ---------------- throughput: 8 independent writers r1..r8
    for (int i = 0; i < 8; i++) thr_w[i] = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'(i + 1), 5'd0, 17'(i));
    for (int i = 0; i < 12; i++) begin
      cyc();
      instr_valid = (i < 8);
      instr       = (i < 8) ? thr_w[i] : 32'h0;
      #1;
      $display("thr cyc=%0d dv=%b stall=%b dec=%h", i, dv, stall, dec_instr);
      chk1($sformatf("thr_ready_%0d", i), instr_ready, 1'b1);
      chk1($sformatf("thr_stall_%0d", i), stall, 1'b0);
      chk1($sformatf("thr_dv_%0d", i), dv, (i >= 2 && i < 10));
      if (i >= 2 && i < 10) chk32($sformatf("thr_dec_%0d", i), dec_instr, thr_w[i - 2]);
    end
    idle(6);

    // ---------------- RAW: write r3, then read r3 as A
    w_p = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 5'd0, 17'h0);
    w_c = mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 17'h0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      instr_valid = (i < 2);
      instr       = (i == 0) ? w_p : w_c;
      #1;
      $display("raw cyc=%0d dv=%b stall=%b dec=%h", i, dv, stall, dec_instr);
      exp_bits = 16'b0000_0000_0001_1100;
      chk1($sformatf("raw_stall_%0d", i), stall, exp_bits[i]);
      exp_bits = 16'b0000_0000_0100_0100;
      chk1($sformatf("raw_dv_%0d", i), dv, exp_bits[i]);
      if (i == 2) chk32("raw_dec_producer", dec_instr, w_p);
      if (i == 6) chk32("raw_dec_consumer", dec_instr, w_c);
    end
    idle(4);

    // ---------------- GMEM read with 4-cycle REQ, stray ACK while REQ low
    w_g = mk(1'b1, 1'b0, 1'b0, 1'b1, 5'd10, 5'd0, 17'h1ABCD);
    for (int i = 0; i < 8; i++) begin
      cyc();
      instr_valid = (i == 0);
      instr       = w_g;
      gmem_ack    = (i == 0) || (i == 4);
      gmem_rdata  = (i == 0) ? 32'h12345678 : ((i == 4) ? 32'hDEADBEEF : 32'h0BADF00D);
      #1;
      $display("gmem cyc=%0d req=%b addr=%h dv=%b gdata=%h", i, gmem_req, gmem_addr, dv, gmem_data);
      chk1($sformatf("gm_req_%0d", i), gmem_req, (i >= 1 && i <= 4));
      if (i >= 1 && i <= 4) chk32($sformatf("gm_addr_%0d", i), {15'h0, gmem_addr}, 32'h0001ABCD);
      exp_bits = 16'b0000_0000_0000_1110;
      chk1($sformatf("gm_stall_%0d", i), stall, exp_bits[i]);
      chk1($sformatf("gm_dv_%0d", i), dv, (i == 5));
      if (i >= 1 && i <= 4) chk32($sformatf("gm_gdata_hold_%0d", i), gmem_data, 32'h0);
      if (i == 5) begin
        chk32("gm_dec", dec_instr, w_g);
        chk32("gm_gdata", gmem_data, 32'hDEADBEEF);
      end
    end
    idle(6);

    // ---------------- full queue under busy, then release
    for (int i = 0; i < 6; i++) bw[i] = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'(11 + i), 5'd0, 17'(i));
    for (int i = 0; i < 12; i++) begin
      cyc();
      busy        = (i < 6);
      instr_valid = (i < 6);
      instr       = (i < 6) ? bw[i] : 32'h0;
      #1;
      $display("busy cyc=%0d ready=%b stall=%b dv=%b ev=%b dec=%h", i, instr_ready, stall, dv, ev, dec_instr);
      chk1($sformatf("bz_ready_%0d", i), instr_ready, !(i >= 4 && i <= 6));
      exp_bits = 16'b0000_0000_0011_1110;
      chk1($sformatf("bz_stall_%0d", i), stall, exp_bits[i]);
      chk1($sformatf("bz_ev_%0d", i), ev, (i >= 8 && i <= 11));
      chk1($sformatf("bz_dv_%0d", i), dv, (i >= 7 && i <= 10));
      if (i >= 7 && i <= 10) chk32($sformatf("bz_dec_%0d", i), dec_instr, bw[i - 7]);
    end
    idle(6);

    // ---------------- flush with 3 queued and a pending GMEM REQ
    w_x  = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd21, 5'd0, 17'h0);
    w_g2 = mk(1'b1, 1'b0, 1'b0, 1'b1, 5'd20, 5'd0, 17'h00055);
    w_y  = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd22, 5'd0, 17'h0);
    w_z  = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd23, 5'd0, 17'h0);
    w_q  = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd24, 5'd0, 17'h0);
    w_r  = mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd21, 17'h0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      instr_valid = (i <= 4) || (i == 6);
      case (i)
        0:       instr = w_x;
        1:       instr = w_g2;
        2:       instr = w_y;
        3:       instr = w_z;
        4:       instr = w_q;
        default: instr = w_r;
      endcase
      flush      = (i == 4);
      gmem_ack   = (i == 4);
      gmem_rdata = 32'hBAD0BAD0;
      #1;
      $display("flush cyc=%0d req=%b ready=%b stall=%b dv=%b wv=%b dec=%h", i, gmem_req, instr_ready, stall, dv, wv, dec_instr);
      if (i != 4) chk1($sformatf("fl_req_%0d", i), gmem_req, (i >= 2 && i <= 3));
      if (i != 4) chk1($sformatf("fl_stall_%0d", i), stall, (i >= 2 && i <= 3));
      chk1($sformatf("fl_ready_%0d", i), instr_ready, (i != 4));
      chk1($sformatf("fl_dv_%0d", i), dv, (i == 2) || (i == 8));
      if (i == 4) begin
        chk1("fl_wv_drain", wv, 1'b1);
        chk32("fl_wb_drain", wb_instr, w_x);
      end
      if (i == 5) chk32("fl_gdata_kept", gmem_data, 32'hDEADBEEF);
      if (i == 8) chk32("fl_dec_reader", dec_instr, w_r);
    end
    idle(6);

    // ---------------- reset mid-operation with r5 pending and E valid
    w_p = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 17'h0);
    w_y = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 5'd0, 17'h0);
    w_r = mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 17'h0);
    for (int i = 0; i < 7; i++) begin
      cyc();
      rst_n       = (i != 3);
      instr_valid = (i <= 2) || (i == 4);
      case (i)
        0:       instr = w_p;
        1:       instr = w_y;
        default: instr = w_r;
      endcase
      #1;
      $display("rst cyc=%0d dv=%b ev=%b wv=%b stall=%b", i, dv, ev, wv, stall);
      if (i == 3) chk1("mr_ev_before", ev, 1'b1);
      if (i == 4) begin
        chk1("mr_dv", dv, 1'b0);
        chk1("mr_ev", ev, 1'b0);
        chk1("mr_wv", wv, 1'b0);
        chk1("mr_req", gmem_req, 1'b0);
        chk1("mr_stall", stall, 1'b0);
      end
      if (i == 5) chk1("mr_no_stall_r5", stall, 1'b0);
      if (i == 6) begin
        chk1("mr_dv_reader", dv, 1'b1);
        chk32("mr_dec_reader", dec_instr, w_r);
      end
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
